// File: rtl/irq_controller.sv
// Prioritised interrupt controller: per-source pending logic, candidate priority
// encoding, and an IDLE/REQ/SERVICE request-acknowledge-EOI handshake to the CPU.

module irq_pend_bit (
  input  logic clock,
  input  logic reset_n,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic w1c,
  input  logic ack_clr,
  output logic pending
);
  logic irq_q;
  logic pend_edge;

  // A detected rising edge outranks any clear in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      irq_q     <= 1'b0;
      pend_edge <= 1'b0;
    end else begin
      irq_q <= irq_in;
      if (!edge_mode)              pend_edge <= 1'b0;
      else if (irq_in && !irq_q)   pend_edge <= 1'b1;
      else if (w1c || ack_clr)     pend_edge <= 1'b0;
    end
  end

  assign pending = edge_mode ? pend_edge : irq_q;
endmodule

module irq_controller #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         addr,
  input  logic [15:0]        write_data,
  input  logic               write_en,
  input  logic               read_en,
  input  logic               chipselect,
  output logic [15:0]        read_data,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cpu_ack,
  output logic               cpu_irq,
  output logic [2:0]         cpu_vector
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [15:0] data;
  } bus_req_t;

  bus_req_t           bus;
  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] enable, mode, pending, cand, w1c, ack_clr;
  logic               gen, insvc, eoi, ack_take;
  logic               win_vld, vec_hit;
  logic [2:0]         vec, win_idx;
  logic [15:0]        rd_mux;
  logic               unused_wdata;

  assign bus.wr   = chipselect && write_en;
  assign bus.rd   = chipselect && read_en;
  assign bus.addr = addr;
  assign bus.data = write_data;
  assign unused_wdata = ^write_data;

  assign eoi      = bus.wr && (bus.addr == 2'd3) && bus.data[15];
  assign ack_take = (state == S_REQ) && cpu_ack;
  assign w1c      = (bus.wr && bus.addr == 2'd0) ? bus.data[NUM_IRQ-1:0] : '0;
  assign cand     = pending & enable;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    assign ack_clr[i] = ack_take && (vec == 3'(i));
    irq_pend_bit u_pend (
      .clock     (clock),
      .reset_n   (reset_n),
      .irq_in    (irq_in[i]),
      .edge_mode (mode[i]),
      .w1c       (w1c[i]),
      .ack_clr   (ack_clr[i]),
      .pending   (pending[i])
    );
  end

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    vec_hit = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_idx = 3'(i);
      end
    end
    for (int i = 0; i < NUM_IRQ; i++)
      if (vec == 3'(i)) vec_hit = cand[i];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (gen && win_vld)        state_nxt = S_REQ;
      S_REQ:     if (cpu_ack)               state_nxt = S_SERVICE;
                 else if (!gen || !vec_hit) state_nxt = S_IDLE;
      S_SERVICE: if (eoi)                   state_nxt = S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_irq = (state == S_REQ);
    insvc   = (state == S_SERVICE);
  end

  always_comb begin
    rd_mux = 16'd0;
    case (bus.addr)
      2'd0: rd_mux = 16'(pending);
      2'd1: rd_mux = 16'(enable);
      2'd2: rd_mux = 16'(mode);
      2'd3: rd_mux = {9'd0, insvc, vec, 2'd0, gen};
      default: rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      enable    <= '0;
      mode      <= '0;
      gen       <= 1'b0;
      vec       <= 3'd0;
      read_data <= 16'd0;
    end else begin
      if (bus.wr) begin
        case (bus.addr)
          2'd1: enable <= bus.data[NUM_IRQ-1:0];
          2'd2: mode   <= bus.data[NUM_IRQ-1:0];
          2'd3: gen    <= bus.data[0];
          default: ;
        endcase
      end
      // VEC is captured only on issue and stays frozen through REQ/SERVICE.
      if (state == S_IDLE && state_nxt == S_REQ) vec <= win_idx;
      if (bus.rd) read_data <= rd_mux;
    end
  end

  assign cpu_vector = vec;
endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed stimulus pushes expected read data
// or irq status; a monitor pops and compares when an observation is due.

module tb_irq_controller;
  localparam int N = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    addr = '0;
  logic [15:0]   write_data = '0;
  logic          write_en = 1'b0, read_en = 1'b0, chipselect = 1'b0;
  logic [15:0]   read_data;
  logic [N-1:0]  irq_in = '0;
  logic          cpu_ack = 1'b0;
  logic          cpu_irq;
  logic [2:0]    cpu_vector;

  irq_controller #(.NUM_IRQ(N)) dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .chipselect(chipselect),
    .read_data(read_data), .irq_in(irq_in), .cpu_ack(cpu_ack),
    .cpu_irq(cpu_irq), .cpu_vector(cpu_vector)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  logic snap = 1'b0;
  logic mon_vld = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) mon_vld <= (chipselect && read_en) || snap;

  always @(negedge clock) begin
    exp_t        e;
    logic [15:0] act;
    if (mon_vld) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_obs: no expectation queued");
      end else begin
        e   = sb.pop_front();
        act = e.is_irq ? {12'd0, cpu_irq, cpu_vector} : read_data;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    chipselect = 1'b0; write_en = 1'b0; read_en = 1'b0; cpu_ack = 1'b0; snap = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_en = 1'b1; addr = a; write_data = d;
    cyc();
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e, input string n);
    sb.push_back('{n, 1'b0, e});
    chipselect = 1'b1; read_en = 1'b1; addr = a;
    cyc();
  endtask

  // Observes cpu_irq/cpu_vector just after the next clock edge.
  task automatic chk_irq(input logic e_irq, input logic [2:0] e_vec, input string n);
    sb.push_back('{n, 1'b1, {12'd0, e_irq, e_vec}});
    snap = 1'b1;
    cyc();
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_in = m;
    cyc();
    irq_in = '0;
  endtask

  task automatic ack();
    cpu_ack = 1'b1;
    cyc();
  endtask

  task automatic rst();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    rd(2'd0, 16'h0000, "reset_pending");
    rd(2'd1, 16'h0000, "reset_enable");
    rd(2'd2, 16'h0000, "reset_mode");
    rd(2'd3, 16'h0000, "reset_ctrl");
    chk_irq(1'b0, 3'd0, "reset_irq");

    // Edge source 0: request, ack, EOI.
    wr(2'd1, 16'h0001); wr(2'd2, 16'h0001); wr(2'd3, 16'h0001);
    pulse(8'h01);
    rd(2'd0, 16'h0001, "a_pending_set");
    chk_irq(1'b1, 3'd0, "a_req_v0");
    ack();
    chk_irq(1'b0, 3'd0, "a_after_ack");
    rd(2'd0, 16'h0000, "a_pending_cleared");
    rd(2'd3, 16'h0041, "a_ctrl_insvc");
    wr(2'd3, 16'h8001);
    chk_irq(1'b0, 3'd0, "a_after_eoi");
    rd(2'd3, 16'h0001, "a_ctrl_idle");

    // Simultaneous edges on 3 and 2: lowest index first, then 3.
    wr(2'd1, 16'h000C); wr(2'd2, 16'h000C);
    pulse(8'h0C);
    chk_irq(1'b1, 3'd2, "b_req_v2");
    ack();
    chk_irq(1'b0, 3'd2, "b_svc_v2");
    rd(2'd0, 16'h0008, "b_pending_3_left");
    wr(2'd3, 16'h8001);
    chk_irq(1'b1, 3'd3, "b_req_v3");
    ack();
    wr(2'd3, 16'h8001);
    chk_irq(1'b0, 3'd3, "b_idle");
    rd(2'd0, 16'h0000, "b_pending_empty");

    // Level source 1 held high: re-requested after EOI, W1C ineffective.
    wr(2'd1, 16'h0002); wr(2'd2, 16'h0000);
    irq_in = 8'h02;
    cyc();
    chk_irq(1'b1, 3'd1, "c_req_v1");
    ack();
    chk_irq(1'b0, 3'd1, "c_svc_v1");
    wr(2'd0, 16'h0002);
    rd(2'd0, 16'h0002, "c_w1c_no_effect");
    wr(2'd3, 16'h8001);
    chk_irq(1'b1, 3'd1, "c_rereq_v1");
    irq_in = '0;
    cyc();
    chk_irq(1'b0, 3'd1, "c_withdraw_level_drop");
    rd(2'd0, 16'h0000, "c_pending_level_low");

    // Withdraw on ENABLE cleared while in REQ.
    wr(2'd1, 16'h0010); wr(2'd2, 16'h0010);
    pulse(8'h10);
    chk_irq(1'b1, 3'd4, "d_req_v4");
    wr(2'd1, 16'h0000);
    chk_irq(1'b0, 3'd4, "d_withdrawn");
    rd(2'd0, 16'h0010, "d_pending4_kept");
    rd(2'd3, 16'h0021, "d_ctrl_idle_vec4");
    ack();
    chk_irq(1'b0, 3'd4, "d_ack_outside_req");
    rd(2'd3, 16'h0021, "d_ctrl_no_insvc");

    // W1C coincident with a rising edge: set wins.
    wr(2'd0, 16'h0010);
    rd(2'd0, 16'h0000, "e_w1c_bit4");
    wr(2'd2, 16'h0001);
    irq_in = 8'h01;
    wr(2'd0, 16'h0001);
    irq_in = '0;
    rd(2'd0, 16'h0001, "e_set_wins");
    wr(2'd0, 16'h0001);
    rd(2'd0, 16'h0000, "e_w1c_plain");
    wr(2'd1, 16'hFFFF);
    rd(2'd1, 16'h00FF, "e_enable_upper_bits");
    wr(2'd1, 16'h0000);

    // Reset while in SERVICE, then EOI is ignored.
    wr(2'd1, 16'h0001);
    pulse(8'h01);
    chk_irq(1'b1, 3'd0, "g_req_v0");
    ack();
    rd(2'd3, 16'h0041, "g_in_service");
    rst();
    rd(2'd0, 16'h0000, "g_rst_pending");
    rd(2'd1, 16'h0000, "g_rst_enable");
    rd(2'd2, 16'h0000, "g_rst_mode");
    rd(2'd3, 16'h0000, "g_rst_ctrl");
    chk_irq(1'b0, 3'd0, "g_rst_irq");
    wr(2'd3, 16'h8000);
    rd(2'd3, 16'h0000, "g_eoi_ignored");

    // Reset during REQ drops the request.
    wr(2'd1, 16'h0004); wr(2'd2, 16'h0004); wr(2'd3, 16'h0001);
    pulse(8'h04);
    chk_irq(1'b1, 3'd2, "h_req_v2");
    rst();
    chk_irq(1'b0, 3'd0, "h_rst_in_req");
    rd(2'd3, 16'h0000, "h_rst_ctrl");

    repeat (3) cyc();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter: NUM_IRQ, default 8, number of interrupt source lines (1..8).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 addr  input  2  Peribus register select.
REQ-005 write_data  input  16  Peribus write data.
REQ-006 write_en  input  1  Peribus write strobe, qualified by chipselect.
REQ-007 read_en  input  1  Peribus read strobe, qualified by chipselect.
REQ-008 chipselect  input  1  Peribus select for this block.
REQ-009 read_data  output  16  registered Peribus read data.
REQ-010 irq_in  input  NUM_IRQ  peripheral interrupt lines (e.g. Timer irq), active-high.
REQ-011 cpu_ack  input  1  CPU acknowledge of cpu_irq, one-cycle pulse.
REQ-012 cpu_irq  output  1  interrupt request to CPU.
REQ-013 cpu_vector  output  3  index of the requested/in-service source.

Function
REQ-014 Register map: 0 PENDING (read; write-1-to-clear), 1 ENABLE, 2 MODE (bit=1 edge, 0 level), 3 CTRL {EOI[15] write-only, 8'h0, INSVC[6], VEC[5:3], 2'h0, GEN[0]}; bits at or above NUM_IRQ read 0 and ignore writes.
REQ-015 read_data SHALL load the addressed register one cycle after chipselect&&read_en and hold otherwise.
REQ-016 irq_in SHALL be registered once (irq_q); edge detection uses irq_in && !irq_q.
REQ-017 Edge-mode pending bit: set on detected rising edge; cleared by PENDING W1C or by cpu_ack for that vector; set wins over simultaneous clear.
REQ-018 Level-mode pending bit SHALL equal irq_q every cycle; W1C and ack have no effect.
REQ-019 Candidate set = PENDING & ENABLE; priority: lowest index wins.
REQ-020 FSM states: IDLE, REQ, SERVICE.
REQ-021 IDLE->REQ when GEN=1 and candidate set nonzero: latch winning index into VEC, cpu_irq=1 next cycle.
REQ-022 REQ: cpu_irq held 1, VEC frozen even if a higher-priority source arrives.
REQ-023 REQ->IDLE (withdraw) when latched source leaves candidate set or GEN cleared before ack: cpu_irq=0 next cycle.
REQ-024 REQ->SERVICE on cpu_ack: cpu_irq=0, INSVC=1, edge-mode pending bit of VEC cleared, same cycle.
REQ-025 SERVICE->IDLE on write to CTRL with write_data[15]=1 (EOI): INSVC=0; new request no earlier than next cycle.
REQ-026 No nesting: no new request issued while in REQ or SERVICE.
REQ-027 cpu_ack outside REQ SHALL be ignored.
REQ-028 cpu_vector SHALL equal VEC at all times.
REQ-029 CTRL write updates GEN; EOI outside SERVICE ignored; INSVC/VEC read-only.

Reset
REQ-030 On reset_n=0 at a clock edge: PENDING, ENABLE, MODE, GEN, VEC, INSVC, irq_q, read_data = 0; cpu_irq = 0; FSM = IDLE, regardless of state mid-handshake.
REQ-031 Reset asserted during REQ SHALL drop cpu_irq on the same edge; no ack is owed.

Verification
REQ-032 ENABLE=0x01, MODE=0x01, GEN=1, pulse irq_in[0] -> PENDING=0x01, cpu_irq=1 with cpu_vector=0 within 3 cycles; cpu_ack -> cpu_irq=0, PENDING=0x00, CTRL reads INSVC=1, VEC=0.
REQ-033 ENABLE=0x0C, edge mode, irq_in[3] and [2] rise same cycle -> cpu_vector=2; after ack+EOI, cpu_vector=3 requested next.
REQ-034 Level-mode line 1 held high through ack+EOI -> request re-issued for vector 1; W1C to PENDING bit1 has no effect.
REQ-035 In REQ for vector 4, write ENABLE=0x00 -> cpu_irq=0 next cycle, FSM IDLE, PENDING bit4 still 1.
REQ-036 W1C of PENDING bit0 same cycle as rising edge on irq_in[0] -> PENDING bit0=1.
REQ-037 reset_n=0 for one cycle while in SERVICE -> all registers 0, cpu_irq=0, EOI afterwards ignored.
